// File: rtl/signed_diff_acc_pkg.sv
// Shared types and helpers for the signed difference accumulator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package signed_diff_acc_pkg;

    // Width of the subtracter's signed difference samples.
    localparam int DIFF_W = 6;

    // Widest intermediate sum handled by sat_clip (ACC_W max 16, plus one guard bit).
    localparam int SAT_W = 17;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Clamp a sign-extended value into the two's complement range of 'width' bits.
    function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] value,
                                                         input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = 17'sd1 <<< (width - 1);
        hi = hi - 17'sd1;
        lo = -hi - 17'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/signed_diff_accumulator_sat_adder.sv
// Saturating adder: acc + operand clamped to ACC_W bits, with an overflow flag.
// Latency: combinational, the parent registers the result.
// Backpressure: none, pure datapath.
module sat_adder
    import signed_diff_acc_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [ACC_W-1:0] operand,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    logic signed [ACC_W:0]   wide;
    logic signed [SAT_W-1:0] wide_x;
    logic signed [SAT_W-1:0] clip;

    // One guard bit makes the raw sum exact; the clamp then folds it back to ACC_W bits.
    always_comb begin
        wide   = {acc[ACC_W-1], acc} + {operand[ACC_W-1], operand};
        wide_x = SAT_W'(wide);
        clip   = sat_clip(wide_x, ACC_W);
        sum    = clip[ACC_W-1:0];
        ovf    = (clip != wide_x);
    end

endmodule

// File: rtl/signed_diff_accumulator.sv
// Sums COUNT signed 6-bit samples per block with saturation; optional min/max via SIGNED_DIFF_ACC_MINMAX_EN.
// Latency: result valid the cycle after the COUNTth accepted sample; one bubble cycle on release.
// Backpressure: in_ready drops for the whole HOLD state; results hold stable until out_ready.
module signed_diff_accumulator
    import signed_diff_acc_pkg::*;
#(
    parameter int COUNT = 8,
    parameter int ACC_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DIFF_W-1:0] diff_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [ACC_W-1:0]  sum,
    output logic signed [DIFF_W-1:0] min,
    output logic signed [DIFF_W-1:0] max,
    output logic                     overflow,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  operand;
    logic signed [ACC_W-1:0]  add_sum;
    logic                     add_ovf;
    logic                     accept;
    logic                     release_blk;

    // Handshake flags come straight off the state register.
    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == HOLD);
    assign accept      = in_valid && (state == ACCUM);
    assign release_blk = out_ready && (state == HOLD);
    assign operand     = {{(ACC_W-DIFF_W){diff_in[DIFF_W-1]}}, diff_in};

    sat_adder #(
        .ACC_W(ACC_W)
    ) u_sat_adder (
        .acc    (sum),
        .operand(operand),
        .sum    (add_sum),
        .ovf    (add_ovf)
    );

    // Block FSM: accumulate COUNT samples, then hold the result until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            cnt      <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        sum      <= add_sum;
                        overflow <= overflow | add_ovf;
                        cnt      <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        sum      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        state    <= ACCUM;
                    end
                end
            endcase
        end
    end

`ifdef SIGNED_DIFF_ACC_MINMAX_EN
    logic first;

    // Track block extremes; the first sample of a block overwrites the previous block's values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min   <= '0;
            max   <= '0;
            first <= 1'b1;
        end else if (accept) begin
            first <= 1'b0;
            if (first) begin
                min <= diff_in;
                max <= diff_in;
            end else begin
                if (diff_in < min) begin
                    min <= diff_in;
                end
                if (diff_in > max) begin
                    max <= diff_in;
                end
            end
        end else if (release_blk) begin
            first <= 1'b1;
        end
    end
`else
    // Min/max tracking not built: report constant zero.
    assign min = '0;
    assign max = '0;
`endif

endmodule

// File: tb/tb_signed_diff_accumulator.sv
// Directed bench: two instances (ACC_W=10 and ACC_W=8) share one stimulus stream.
// Latency: results checked the cycle after the last sample.
// Backpressure: exercises HOLD stalls, release bubble and gapped input.
module tb_signed_diff_accumulator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [5:0] diff_in;
    logic              in_valid;
    logic              out_ready;

    logic              in_ready10, out_valid10, ovf10;
    logic signed [9:0] sum10;
    logic signed [5:0] min10, max10;
    logic              in_ready8, out_valid8, ovf8;
    logic signed [7:0] sum8;
    logic signed [5:0] min8, max8;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    signed_diff_accumulator #(.COUNT(8), .ACC_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .diff_in(diff_in), .in_valid(in_valid),
        .in_ready(in_ready10), .sum(sum10), .min(min10), .max(max10),
        .overflow(ovf10), .out_valid(out_valid10), .out_ready(out_ready)
    );

    signed_diff_accumulator #(.COUNT(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .diff_in(diff_in), .in_valid(in_valid),
        .in_ready(in_ready8), .sum(sum8), .min(min8), .max(max8),
        .overflow(ovf8), .out_valid(out_valid8), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Expected min/max depend on whether tracking is built.
    function automatic int mm(input int v);
`ifdef SIGNED_DIFF_ACC_MINMAX_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Present one sample at a negedge and return at the negedge after it was accepted.
    task automatic push(input int v);
        int n;
        n = 0;
        diff_in  = 6'(v);
        in_valid = 1'b1;
        while (!in_ready10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic release_blk();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_block(input string tag, input int s10, input int s8,
                               input int mn, input int mx, input int o10, input int o8);
        chk({tag, "_vld10"}, out_valid10, 1);
        chk({tag, "_vld8"}, out_valid8, 1);
        chk({tag, "_rdy10"}, in_ready10, 0);
        chk({tag, "_sum10"}, sum10, s10);
        chk({tag, "_sum8"}, sum8, s8);
        chk({tag, "_ovf10"}, ovf10, o10);
        chk({tag, "_ovf8"}, ovf8, o8);
        chk({tag, "_min10"}, min10, mm(mn));
        chk({tag, "_max8"}, max8, mm(mx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        diff_in   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        idle(2);
        chk("rst_sum10", sum10, 0);
        chk("rst_min", min10, 0);
        chk("rst_max", max10, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst_vld", out_valid10, 0);
        chk("rst_rdy", in_ready10, 1);
        rst_n = 1'b1;
        idle(1);

        // Ascending block; out_ready held early must not matter.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(i);
        out_ready = 1'b0;
        for (int i = 5; i <= 7; i++) push(i);
        chk("asc_vld_early", out_valid10, 0);
        push(8);
        check_block("asc", 36, 36, 1, 8, 0, 0);
        release_blk();

        // Mixed signs, then backpressure with junk on the input.
        push(-30); push(30); push(-5); push(12); push(0); push(-1); push(7); push(-13);
        check_block("mix", 0, 0, -30, 30, 0, 0);
        diff_in  = 6'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_vld", out_valid8, 1);
            chk("bp_rdy", in_ready8, 0);
            chk("bp_sum", sum10, 0);
            chk("bp_min", min8, mm(-30));
        end
        in_valid = 1'b0;
        release_blk();
        chk("rel_rdy", in_ready10, 1);
        chk("rel_sum", sum10, 0);

        // Positive saturation in the narrow instance only.
        for (int i = 0; i < 8; i++) push(30);
        check_block("pos", 240, 127, 30, 30, 0, 1);
        release_blk();
        chk("rel_ovf_clr", ovf8, 0);
        chk("rel_min_keep", min8, mm(30));

        // Negative saturation.
        for (int i = 0; i < 8; i++) push(-30);
        check_block("neg", -240, -128, -30, -30, 0, 1);
        release_blk();

        // Saturate then come back into range: overflow stays set.
        for (int i = 0; i < 5; i++) push(31);
        for (int i = 0; i < 3; i++) push(-32);
        check_block("sticky", 59, 31, -32, 31, 0, 1);
        release_blk();

        // Gapped input: one idle cycle between samples.
        for (int i = 1; i <= 8; i++) begin
            push(i);
            if (i == 7) chk("gap_vld_early", out_valid10, 0);
            if (i != 8) idle(1);
        end
        check_block("gap", 36, 36, 1, 8, 0, 0);
        release_blk();

        // Reset mid-block discards partial data asynchronously.
        push(10); push(10); push(10);
        chk("part_sum", sum8, 30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sum", sum8, 0);
        chk("arst_max", max10, 0);
        chk("arst_rdy", in_ready10, 1);
        chk("arst_vld", out_valid10, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        for (int i = 1; i <= 8; i++) push(-i);
        check_block("post_rst", -36, -36, -8, -1, 0, 0);
        release_blk();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/signed_diff_accumulator.md
# signed_diff_accumulator

Block-level accumulator placed directly downstream of the sign-magnitude subtracter. It consumes the subtracter's 6-bit signed difference stream through a valid/ready handshake and sums COUNT samples per block with saturation. It reports each block's sum, its minimum and maximum sample, and a sticky overflow flag to the next stage through a second valid/ready handshake.

## Interface
- COUNT, default 8: samples per block; legal range 2..64.
- ACC_W, default 10: sum width in bits, two's complement; legal range 7..16.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Diff_in  in  6  signed difference from the subtracter (two's complement, range -32..31).
- In_valid  in  1  Diff_in is valid.
- In_ready  out  1  block accepts Diff_in in this cycle.
- Sum  out  ACC_W  signed saturated block sum.
- Min, Max  out  6 each  signed minimum and maximum sample of the block.
- Overflow  out  1  saturation occurred at least once in the block.
- Out_valid  out  1  Sum, Min, Max and Overflow are valid.
- Out_ready  in  1  downstream accepts the result.

## Operation
- Two-state FSM:
  - ACCUM: In_ready=1, Out_valid=0.
  - HOLD: In_ready=0, Out_valid=1.
- Accept rule: a sample is accepted when In_valid and In_ready are both high.
- ACCUM, on each accepted sample:
  - acc <= sat(acc + sext(Diff_in)).
  - cnt <= cnt+1.
  - Min/Max updated by signed compare. The first sample of a block loads both directly.
- Move to HOLD on the accepted sample where cnt==COUNT-1.
- HOLD, when Out_ready is high:
  - acc, cnt and Overflow cleared; first-sample flag set.
  - Next state is ACCUM.
  - Min/Max keep their last values until the first sample of the new block loads them.
- Saturation:
  - Sum is computed at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1, clamp to that value. Below -2^(ACC_W-1), clamp to that value.
  - Either clamp sets Overflow, which stays set until the block is released.
- Outputs in HOLD are stable and do not change while Out_valid=1 and Out_ready=0.
- Reset values: state=ACCUM, acc=0, cnt=0, Sum=0, Min=0, Max=0, Overflow=0, Out_valid=0, In_ready=1 (reflects state), first-sample flag=1.
- Reset asserted mid-block or in HOLD discards all partial data immediately, with no output.

## Timing
- All outputs are registered; In_ready and Out_valid are decoded from the state register only.
- Out_valid rises in the cycle after the COUNTth accepted sample.
- The release handshake costs one bubble cycle. The next sample can be accepted in the cycle after the Out_ready handshake.
- Peak throughput is one block per COUNT+1 cycles.
- In_valid during HOLD is ignored; the upstream source must hold its data.
- Out_ready asserted before Out_valid has no effect.
- Back-to-back input with In_valid held high: COUNT consecutive accepts, then In_ready=0 until release.

## Configuration
- SIGNED_DIFF_ACC_MINMAX_EN:
  - Defined: Min/Max tracking is built as described above.
  - Undefined: the compare logic and registers are removed, and Min and Max are driven constant 0.
  - Sum, Overflow and the handshake behaviour are identical in both builds.

## Structure
- Package signed_diff_acc_pkg holds:
  - constant DIFF_W=6;
  - the FSM state typedef {ACCUM, HOLD};
  - helper function sat_clip(value, width).
- One sub-module, sat_adder (ACC_W-parameterised):
  - Inputs: a signed accumulator and a sign-extended operand.
  - Outputs: the clamped sum and an overflow bit.
  - It is combinational; the parent registers the result.

## Test plan
- COUNT=8, ACC_W=10; inputs 1,2,3,4,5,6,7,8 on consecutive cycles -> Out_valid one cycle after the 8th sample; Sum=36, Min=1, Max=8, Overflow=0.
- Mixed signs: -30,30,-5,12,0,-1,7,-13 -> Sum=0, Min=-30, Max=30.
- ACC_W=8; eight samples of +30 -> Sum=127, Overflow=1. Eight samples of -30 in the next block -> Sum=-128, Overflow=1.
- Backpressure: Out_ready held low for 5 cycles after Out_valid -> outputs stable and In_ready=0 throughout. Out_ready pulse -> next block's first sample accepted in the following cycle, and its Sum excludes prior data.
- Gapped input: In_valid toggling every other cycle -> same Sum as the back-to-back case; cnt advances only on handshakes.
- Reset driven low after 3 samples -> all outputs 0 asynchronously. After release, a fresh 8-sample block produces the correct Sum. With SIGNED_DIFF_ACC_MINMAX_EN undefined, Min=Max=0 in every block.
